mu0_run_controller: RTL and testbench
=====================================

# mu0_run_controller

Synthesisable run controller for the MU0 processor: sequences the processor's reset, runs the program one or more times, and measures the cycles to `Halted` with a programmable timeout. It also counts memory writes and captures writes to a watch address. It sits between the board/test harness and the `MU0` core plus `MU0_Memory`, and generalises the fixed reset-then-wait-then-stop sequence into a parametrised, self-checking, multi-run block.

## Interface
- `ADDR_W`, 12: MU0 address width.
- `DATA_W`, 16: MU0 data width.
- `RESET_CYCLES`, 1: cycles `cpu_reset` is held high per run (≥1).
- `CNT_W`, 16: width of cycle counter and timeout limit.
- `RUNS_W`, 4: width of run count.
- `WCNT_W`, 16: width of write counter.

Ports:
- `Clk` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `run_count` in RUNS_W: runs per sequence; 0 is treated as 1.
- `timeout_limit` in CNT_W: cycle budget per run; 0 means 2^CNT_W−1.
- `watch_en` in 1: enable watch-address capture.
- `watch_addr` in ADDR_W: address to watch.
- `cpu_reset` out 1: active-high reset to MU0.
- `cpu_halted` in 1: MU0 `Halted`.
- `cpu_wr` in 1: MU0 `Wr`.
- `cpu_addr` in ADDR_W: MU0 `Addr`.
- `cpu_dout` in DATA_W: MU0 `Dout`.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse at sequence end.
- `timed_out` out 1: sticky; last sequence aborted on timeout.
- `inconsistent` out 1: sticky; a later run's halt cycle count differed from run 1's.
- `cycle_count` out CNT_W: cycles of the current or last run.
- `runs_done` out RUNS_W: runs completed with halt.
- `write_count` out WCNT_W: writes across all runs; saturates.
- `watch_hit` out 1: sticky; a watched write occurred.
- `watch_data` out DATA_W: data of the most recent watched write.

## Operation
- Reset values: state IDLE, `cpu_reset`=1, all other outputs 0. A `Reset` assertion mid-run aborts immediately and asynchronously forces `cpu_reset`=1.
- IDLE: `cpu_reset`=1 and results are held. When `start`=1:
  - clear `timed_out`, `inconsistent`, `cycle_count`, `runs_done`, `write_count`, `watch_hit`, `watch_data`;
  - latch `run_count`, `timeout_limit`, `watch_addr`, `watch_en`;
  - go to HOLD.
- `start` outside IDLE is ignored.
- HOLD: `cpu_reset`=1 for exactly RESET_CYCLES cycles, with `cycle_count` cleared. Then go to RUN.
- RUN: `cpu_reset`=0. On each edge:
  - `cpu_halted`=1 → increment `runs_done` and hold `cycle_count`.
    - First run: store `cycle_count` as the reference.
    - Later runs: set `inconsistent` if `cycle_count` ≠ reference.
    - If `runs_done`+1 < latched run count → HOLD; else → DONE.
  - `cpu_halted`=0 and `cycle_count` = limit−1 → increment `cycle_count` to the limit, set `timed_out`, go to DONE. Remaining runs are abandoned.
  - Otherwise increment `cycle_count`.
  - Halt and timeout on the same edge: halt wins.
- Write monitor, active in RUN only:
  - `cpu_wr`=1 increments `write_count`, saturating at all-ones.
  - If the latched watch is enabled and `cpu_addr` = latched address, capture `cpu_dout` into `watch_data` and set `watch_hit`.
  - A write on the same edge as a halt is counted.
- DONE: `cpu_reset`=1, `done`=1 for one cycle, then go to IDLE.

## Timing
- `start` sampled high at edge k → `busy`=1 and `cpu_reset`=1 from k.
- `cpu_reset` falls after edge k+RESET_CYCLES.
- A halt sampled at edge h → `done` high in cycle h+1 for single-run sequences. Multi-run sequences re-enter HOLD at h.
- Run N+1 begins RESET_CYCLES cycles after run N's halt.
- `cycle_count` equals the number of RUN edges with `cpu_halted`=0 before the halting edge.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
- Reference program (STP after 34 instructions), `run_count`=1, `timeout_limit`=1000, RESET_CYCLES=1:
  - `cycle_count`=34, `runs_done`=1, `timed_out`=0;
  - `done` pulses once; `cpu_reset` returns to 1.
- Same program, `run_count`=3:
  - `runs_done`=3, `inconsistent`=0;
  - exactly three `cpu_reset` low windows;
  - `write_count` = 3× the single-run count.
- Looping program (no STP), `timeout_limit`=50:
  - `timed_out`=1, `cycle_count`=50, `runs_done`=0;
  - `done` pulses at the 50th RUN edge + 1.
- `watch_en`=1, `watch_addr`=0x0FF, program writes 0x1234 then 0xBEEF to 0x0FF:
  - `watch_hit`=1, `watch_data`=0xBEEF;
  - writes to other addresses are counted but not captured.
- `Reset` driven low mid-RUN:
  - `cpu_reset`=1 immediately; all outputs 0;
  - `start` after release runs normally;
  - `start` pulsed while `busy`=1 has no effect.
- Halt and timeout coincide (halt at 34, `timeout_limit`=35): `timed_out`=0, `cycle_count`=34, `runs_done`=1.

Source files
------------

// File: rtl/mu0_run_controller.sv
// Run controller for the MU0 core.
//
// Holds the core in reset for RESET_CYCLES cycles, releases it, and counts cycles until it
// raises Halted or the per-run budget runs out. This repeats for the requested number of runs.
// While a run is active it also counts memory writes (saturating) and captures the data of
// writes to a watched address.
//
// Ports
//   Clk, Reset      clock (rising edge) and asynchronous active-low reset
//   start           begin a sequence (only honoured while idle)
//   run_count       runs per sequence (0 behaves as 1)
//   timeout_limit   cycle budget per run (0 behaves as all-ones)
//   watch_en/addr   watched-write capture enable and address
//   cpu_reset       active-high reset to the core
//   cpu_halted/wr/addr/dout   core status and write bus
//   busy, done      sequence active / one-cycle end-of-sequence pulse
//   timed_out, inconsistent, watch_hit   sticky result flags
//   cycle_count, runs_done, write_count, watch_data   result values
module mu0_run_controller #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned RUNS_W       = 4,
  parameter int unsigned WCNT_W       = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [RUNS_W-1:0] run_count,
  input  logic [CNT_W-1:0]  timeout_limit,
  input  logic              watch_en,
  input  logic [ADDR_W-1:0] watch_addr,
  output logic              cpu_reset,
  input  logic              cpu_halted,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic              inconsistent,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [RUNS_W-1:0] runs_done,
  output logic [WCNT_W-1:0] write_count,
  output logic              watch_hit,
  output logic [DATA_W-1:0] watch_data
);

  typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_e;

  localparam int unsigned     HoldW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_CYCLES - 1);

  state_e              state_q, state_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    ref_q, ref_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [RUNS_W-1:0]   runs_q, runs_d;
  logic [RUNS_W-1:0]   runs_lat_q, runs_lat_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic                whit_q, whit_d;
  logic                tout_q, tout_d;
  logic                incons_q, incons_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cycle_d    = cycle_q;
    ref_d      = ref_q;
    limit_d    = limit_q;
    runs_d     = runs_q;
    runs_lat_d = runs_lat_q;
    wcnt_d     = wcnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wen_d      = wen_q;
    whit_d     = whit_q;
    tout_d     = tout_q;
    incons_d   = incons_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tout_d     = 1'b0;
          incons_d   = 1'b0;
          cycle_d    = '0;
          runs_d     = '0;
          wcnt_d     = '0;
          whit_d     = 1'b0;
          wdata_d    = '0;
          // Zero settings are mapped here so the run logic never sees them.
          runs_lat_d = (run_count == '0) ? RUNS_W'(1) : run_count;
          limit_d    = (timeout_limit == '0) ? '1 : timeout_limit;
          waddr_d    = watch_addr;
          wen_d      = watch_en;
          hold_cnt_d = '0;
          state_d    = StHold;
        end
      end

      StHold: begin
        cycle_d = '0;
        if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end

      StRun: begin
        if (cpu_wr) begin
          if (wcnt_q != '1) begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
          if (wen_q && (cpu_addr == waddr_q)) begin
            whit_d  = 1'b1;
            wdata_d = cpu_dout;
          end
        end

        // Halt takes priority over a timeout on the same edge.
        if (cpu_halted) begin
          runs_d = runs_q + RUNS_W'(1);
          if (runs_q == '0) begin
            ref_d = cycle_q;
          end else if (cycle_q != ref_q) begin
            incons_d = 1'b1;
          end
          hold_cnt_d = '0;
          state_d    = (runs_d < runs_lat_q) ? StHold : StDone;
        end else if (cycle_q == (limit_q - CNT_W'(1))) begin
          cycle_d = limit_q;
          tout_d  = 1'b1;
          state_d = StDone;
        end else begin
          cycle_d = cycle_q + CNT_W'(1);
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      cycle_q    <= '0;
      ref_q      <= '0;
      limit_q    <= '0;
      runs_q     <= '0;
      runs_lat_q <= '0;
      wcnt_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wen_q      <= 1'b0;
      whit_q     <= 1'b0;
      tout_q     <= 1'b0;
      incons_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cycle_q    <= cycle_d;
      ref_q      <= ref_d;
      limit_q    <= limit_d;
      runs_q     <= runs_d;
      runs_lat_q <= runs_lat_d;
      wcnt_q     <= wcnt_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wen_q      <= wen_d;
      whit_q     <= whit_d;
      tout_q     <= tout_d;
      incons_q   <= incons_d;
    end
  end

  // Status outputs decode straight from the state register, so reset forces cpu_reset high
  // asynchronously and no input reaches an output combinationally.
  assign busy         = (state_q != StIdle);
  assign cpu_reset    = (state_q != StRun);
  assign done         = (state_q == StDone);
  assign timed_out    = tout_q;
  assign inconsistent = incons_q;
  assign cycle_count  = cycle_q;
  assign runs_done    = runs_q;
  assign write_count  = wcnt_q;
  assign watch_hit    = whit_q;
  assign watch_data   = wdata_q;

endmodule

// File: tb/tb_mu0_run_controller.sv
// Bench for mu0_run_controller: a scripted stand-in for the MU0 core drives halts and writes,
// and a sequence-level model predicts every output on every cycle.
module tb_mu0_run_controller;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RC     = 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned RUNS_W = 4;
  localparam int unsigned WCNT_W = 16;
  localparam int          MaxWr  = 8;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              start = 1'b0;
  logic [RUNS_W-1:0] run_count = '0;
  logic [CNT_W-1:0]  timeout_limit = '0;
  logic              watch_en = 1'b0;
  logic [ADDR_W-1:0] watch_addr = '0;
  logic              cpu_reset, cpu_halted, cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_dout;
  logic              busy, done, timed_out, inconsistent, watch_hit;
  logic [CNT_W-1:0]  cycle_count;
  logic [RUNS_W-1:0] runs_done;
  logic [WCNT_W-1:0] write_count;
  logic [DATA_W-1:0] watch_data;

  int n_err = 0;
  int n_checks = 0;

  always #5 Clk = ~Clk;

  mu0_run_controller #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_CYCLES(RC),
    .CNT_W(CNT_W), .RUNS_W(RUNS_W), .WCNT_W(WCNT_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .run_count(run_count),
    .timeout_limit(timeout_limit), .watch_en(watch_en), .watch_addr(watch_addr),
    .cpu_reset(cpu_reset), .cpu_halted(cpu_halted), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .busy(busy), .done(done), .timed_out(timed_out),
    .inconsistent(inconsistent), .cycle_count(cycle_count), .runs_done(runs_done),
    .write_count(write_count), .watch_hit(watch_hit), .watch_data(watch_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Program script: halt_tab[r] = core cycles before Halted in run r (0 = never halts);
  // writes happen at core cycle wr_t[i] of every run (table sorted by time).
  int halt_tab [4];
  int wr_t [MaxWr];
  int wr_a [MaxWr];
  int wr_d [MaxWr];
  int n_wr;

  int stub_t = 0;
  int stub_run = 0;
  int cur_halt;

  always @(posedge Clk) begin
    if (start && !busy) stub_run <= 0;
    else if (!cpu_reset && cpu_halted) stub_run <= stub_run + 1;
    if (cpu_reset) stub_t <= 0;
    else stub_t <= stub_t + 1;
  end

  always_comb begin
    cur_halt   = halt_tab[(stub_run > 3) ? 3 : stub_run];
    cpu_halted = (cur_halt != 0) && (stub_t >= cur_halt);
    cpu_wr     = 1'b0;
    cpu_addr   = '0;
    cpu_dout   = '0;
    for (int i = 0; i < MaxWr; i++) begin
      if (i < n_wr && wr_t[i] == stub_t) begin
        cpu_wr   = 1'b1;
        cpu_addr = ADDR_W'(wr_a[i]);
        cpu_dout = DATA_W'(wr_d[i]);
      end
    end
  end

  // Sequence-level model: settings and script captured at the accepted start.
  typedef struct {
    int busy; int crst; int done; int to; int inc; int cc; int rd; int wc; int wh; int wd;
  } exp_t;

  bit trk = 1'b0;
  int n_q = 0;
  int m_runs, m_limit, m_waddr, m_wen, m_nwr;
  int m_halt [4];
  int m_wt [MaxWr];
  int m_wa [MaxWr];
  int m_wd [MaxWr];

  function automatic exp_t idle_exp();
    exp_t e;
    e = '{busy: 0, crst: 1, done: 0, to: 0, inc: 0, cc: 0, rd: 0, wc: 0, wh: 0, wd: 0};
    return e;
  endfunction

  // Apply every scripted write with core time < upto, in order.
  function automatic exp_t add_writes(input exp_t ein, input int upto);
    exp_t e;
    e = ein;
    for (int i = 0; i < m_nwr; i++) begin
      if (m_wt[i] < upto) begin
        if (e.wc < (1 << WCNT_W) - 1) e.wc++;
        if (m_wen != 0 && m_wa[i] == m_waddr) begin
          e.wh = 1;
          e.wd = m_wd[i];
        end
      end
    end
    return e;
  endfunction

  // Outputs after the n-th edge following the accepted start edge.
  function automatic exp_t model(input int n);
    exp_t e;
    int nr, lim, base, h, len, q;
    bit halts;
    e = idle_exp();
    e.busy = 1;
    nr = (m_runs == 0) ? 1 : m_runs;
    lim = (m_limit == 0) ? (1 << CNT_W) - 1 : m_limit;
    base = 0;
    for (int r = 0; r < nr; r++) begin
      h = m_halt[(r > 3) ? 3 : r];
      halts = (h != 0) && (h + 1 <= lim);
      len = halts ? h + 1 : lim;
      q = n - base;
      if (q < int'(RC)) begin
        if (q > 0) e.cc = 0;
        return e;
      end
      if (q < int'(RC) + len) begin
        e.crst = 0;
        e.cc = q - int'(RC);
        return add_writes(e, q - int'(RC));
      end
      e = add_writes(e, len);
      e.cc = halts ? h : lim;
      base += int'(RC) + len;
      if (!halts) begin
        e.to = 1;
        break;
      end
      e.rd = r + 1;
      if (r > 0 && h != m_halt[0]) e.inc = 1;
    end
    e.done = (n == base) ? 1 : 0;
    e.busy = e.done;
    return e;
  endfunction

  function automatic bit model_idle();
    exp_t e;
    if (!trk) return 1'b1;
    e = model(n_q);
    return (e.busy == 0);
  endfunction

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      trk <= 1'b0;
      n_q <= 0;
    end else if (model_idle() && start) begin
      trk     <= 1'b1;
      n_q     <= 0;
      m_runs  <= int'(run_count);
      m_limit <= int'(timeout_limit);
      m_waddr <= int'(watch_addr);
      m_wen   <= int'(watch_en);
      m_nwr   <= n_wr;
      m_halt  <= halt_tab;
      m_wt    <= wr_t;
      m_wa    <= wr_a;
      m_wd    <= wr_d;
    end else if (trk) begin
      n_q <= n_q + 1;
    end
  end

  always @(negedge Clk) begin : cmp
    exp_t e;
    e = trk ? model(n_q) : idle_exp();
    check("busy", 64'(busy), 64'(e.busy));
    check("cpu_reset", 64'(cpu_reset), 64'(e.crst));
    check("done", 64'(done), 64'(e.done));
    check("timed_out", 64'(timed_out), 64'(e.to));
    check("inconsistent", 64'(inconsistent), 64'(e.inc));
    check("cycle_count", 64'(cycle_count), 64'(e.cc));
    check("runs_done", 64'(runs_done), 64'(e.rd));
    check("write_count", 64'(write_count), 64'(e.wc));
    check("watch_hit", 64'(watch_hit), 64'(e.wh));
    check("watch_data", 64'(watch_data), 64'(e.wd));
  end

  // Cumulative event counters; tests take differences.
  int done_cnt = 0;
  int fall_cnt = 0;
  int run_cyc = 0;
  logic prev_rst = 1'b1;
  always @(negedge Clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (prev_rst === 1'b1 && cpu_reset === 1'b0) fall_cnt <= fall_cnt + 1;
    if (cpu_reset === 1'b0) run_cyc <= run_cyc + 1;
    prev_rst <= cpu_reset;
  end

  task automatic set_ref_prog(input int h);
    for (int r = 0; r < 4; r++) halt_tab[r] = h;
    n_wr = 3;
    wr_t[0] = 0;  wr_a[0] = 'h020; wr_d[0] = 'h0001;
    wr_t[1] = 17; wr_a[1] = 'h021; wr_d[1] = 'h0002;
    wr_t[2] = 34; wr_a[2] = 'h022; wr_d[2] = 'h0003;
  endtask

  task automatic start_seq(input int runs, input int lim, input bit wen, input int waddr);
    @(negedge Clk);
    run_count = RUNS_W'(runs);
    timeout_limit = CNT_W'(lim);
    watch_en = wen;
    watch_addr = ADDR_W'(waddr);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check(name, 64'(done), 64'(1));
    @(negedge Clk);
    #1;
  endtask

  int d0, f0, c0;

  initial begin
    set_ref_prog(34);
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cycle_count", 64'(cycle_count), 64'(0));
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    #1;

    // Single run of the reference program.
    d0 = done_cnt; f0 = fall_cnt; c0 = run_cyc;
    start_seq(1, 1000, 1'b0, 'h0FF);
    wait_done("t1_done_seen", 2000);
    check("t1_cycle_count", 64'(cycle_count), 64'(34));
    check("t1_runs_done", 64'(runs_done), 64'(1));
    check("t1_timed_out", 64'(timed_out), 64'(0));
    check("t1_write_count", 64'(write_count), 64'(3));
    check("t1_done_pulses", 64'(done_cnt - d0), 64'(1));
    check("t1_cpu_reset_back", 64'(cpu_reset), 64'(1));
    check("t1_run_cycles", 64'(run_cyc - c0), 64'(35));

    // Three runs.
    d0 = done_cnt; f0 = fall_cnt;
    start_seq(3, 1000, 1'b0, 'h0FF);
    wait_done("t2_done_seen", 2000);
    check("t2_runs_done", 64'(runs_done), 64'(3));
    check("t2_inconsistent", 64'(inconsistent), 64'(0));
    check("t2_reset_windows", 64'(fall_cnt - f0), 64'(3));
    check("t2_write_count", 64'(write_count), 64'(9));
    check("t2_done_pulses", 64'(done_cnt - d0), 64'(1));

    // Program that never halts.
    set_ref_prog(0);
    c0 = run_cyc;
    start_seq(2, 50, 1'b0, 'h0FF);
    wait_done("t3_done_seen", 2000);
    check("t3_timed_out", 64'(timed_out), 64'(1));
    check("t3_cycle_count", 64'(cycle_count), 64'(50));
    check("t3_runs_done", 64'(runs_done), 64'(0));
    check("t3_run_cycles", 64'(run_cyc - c0), 64'(50));
    check("t3_write_count", 64'(write_count), 64'(3));

    // Watched writes, plus a start pulse while busy that must be ignored.
    for (int r = 0; r < 4; r++) halt_tab[r] = 20;
    n_wr = 5;
    wr_t[0] = 0;  wr_a[0] = 'h020; wr_d[0] = 'h0001;
    wr_t[1] = 3;  wr_a[1] = 'h0FF; wr_d[1] = 'h1234;
    wr_t[2] = 8;  wr_a[2] = 'h100; wr_d[2] = 'h5555;
    wr_t[3] = 12; wr_a[3] = 'h0FF; wr_d[3] = 'hBEEF;
    wr_t[4] = 15; wr_a[4] = 'h0FE; wr_d[4] = 'h7777;
    start_seq(1, 1000, 1'b1, 'h0FF);
    repeat (5) @(negedge Clk);
    run_count = RUNS_W'(5);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_done("t4_done_seen", 2000);
    check("t4_watch_hit", 64'(watch_hit), 64'(1));
    check("t4_watch_data", 64'(watch_data), 64'('hBEEF));
    check("t4_write_count", 64'(write_count), 64'(5));
    check("t4_runs_done", 64'(runs_done), 64'(1));
    repeat (3) @(negedge Clk);

    // Asynchronous reset in the middle of a run.
    set_ref_prog(34);
    start_seq(3, 1000, 1'b0, 'h0FF);
    repeat (10) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("t5_cpu_reset", 64'(cpu_reset), 64'(1));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_write_count", 64'(write_count), 64'(0));
    check("t5_cycle_count", 64'(cycle_count), 64'(0));
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    start_seq(1, 1000, 1'b0, 'h0FF);
    wait_done("t5_done_seen", 2000);
    check("t5_after_cycle_count", 64'(cycle_count), 64'(34));

    // Halt on the same edge the budget would expire, then one cycle earlier budget.
    start_seq(1, 35, 1'b0, 'h0FF);
    wait_done("t6_done_seen", 2000);
    check("t6_timed_out", 64'(timed_out), 64'(0));
    check("t6_cycle_count", 64'(cycle_count), 64'(34));
    check("t6_runs_done", 64'(runs_done), 64'(1));
    start_seq(1, 34, 1'b0, 'h0FF);
    wait_done("t6b_done_seen", 2000);
    check("t6b_timed_out", 64'(timed_out), 64'(1));
    check("t6b_runs_done", 64'(runs_done), 64'(0));

    // Third run halts later than the first.
    halt_tab[2] = 36;
    start_seq(3, 1000, 1'b0, 'h0FF);
    wait_done("t7_done_seen", 2000);
    check("t7_inconsistent", 64'(inconsistent), 64'(1));
    check("t7_cycle_count", 64'(cycle_count), 64'(36));
    check("t7_runs_done", 64'(runs_done), 64'(3));

    // run_count of zero behaves as one run.
    set_ref_prog(34);
    start_seq(0, 1000, 1'b0, 'h0FF);
    wait_done("t8_done_seen", 2000);
    check("t8_runs_done", 64'(runs_done), 64'(1));
    check("t8_inconsistent", 64'(inconsistent), 64'(0));
    repeat (3) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
